// File: rtl/pac_flash_writer_pkg.sv
// Shared PAC save/load configuration: flash and SD-RAM placement of the 8 KB PAC image,
// the flash operation encoding shared with the flash controller, and the writer FSM states.
package pac_flash_writer_pkg;

    localparam logic [23:0] FLASH_ADDR_PAC   = 24'h1F_0000;
    localparam logic [23:0] FLASH_SIZE_PAC   = 24'h00_2000;
    localparam logic [23:0] RAM_ADDR_PAC     = 24'h77_E000;
    localparam logic [23:0] RAM_SIZE_PAC     = 24'h00_2000;
    localparam bit          ENABLE_PAC_WRITE = 1'b1;
    localparam int          PAC_DATA_W       = 8;

    typedef enum logic {
        ERASE_64K    = 1'b0,
        PROGRAM_PAGE = 1'b1
    } flash_op_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ERASE_REQ  = 3'd1,
        S_ERASE_WAIT = 3'd2,
        S_FILL       = 3'd3,
        S_PROG_REQ   = 3'd4,
        S_PROG_WAIT  = 3'd5,
        S_FINISH     = 3'd6
    } pfw_state_t;

endpackage

// File: rtl/pac_flash_writer_buffer.sv
// One-page staging buffer: write port filled from SD-RAM, registered read port feeding flash
// program data with one cycle of latency. The array has no reset so it can map onto a BSRAM.
module pac_page_buffer
    import pac_flash_writer_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [PAC_DATA_W-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [PAC_DATA_W-1:0] o_rd_data
);

    logic [PAC_DATA_W-1:0] r_mem [DEPTH];
    logic [PAC_DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output holds its last value unless a read is issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pac_flash_writer.sv
// Saves the PAC SRAM image from SD-RAM into configuration flash: one 64 KB erase, then
// page-by-page staging through a local buffer and PROGRAM_PAGE of each page in order.
//   IDLE/FINISH       : waiting for start / one-cycle done pulse
//   ERASE_REQ/WAIT    : erase requested / erase in progress
//   FILL              : staging one page from SD-RAM into the buffer
//   PROG_REQ/WAIT     : program requested / flash pulling bytes until flash_done
module pac_flash_writer
    import pac_flash_writer_pkg::*;
#(
    parameter bit ENABLE     = ENABLE_PAC_WRITE,
    parameter int PAGE_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ram_req,
    output logic [23:0] ram_addr,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata,
    output logic        flash_req,
    output logic        flash_op,
    output logic [23:0] flash_addr,
    input  logic        flash_ack,
    input  logic        flash_dreq,
    output logic [7:0]  flash_wdata,
    input  logic        flash_done,
    input  logic        flash_err
);

    localparam int BYTE_W = $clog2(PAGE_BYTES);
    localparam int NPAGES = int'(RAM_SIZE_PAC) / PAGE_BYTES;
    localparam int PAGE_W = $clog2(NPAGES);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NPAGES - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PAGE_BYTES - 1);

    pfw_state_t        r_state, w_state_nxt;
    logic [PAGE_W-1:0] r_page, w_page_nxt;
    logic [BYTE_W-1:0] r_byte, w_byte_nxt;
    logic [BYTE_W-1:0] r_rptr, w_rptr_nxt;
    logic              r_error, w_error_nxt;

    logic              r_busy, r_done, r_ram_req, r_flash_req;
    logic [23:0]       r_ram_addr, r_flash_addr;
    flash_op_t         r_flash_op;
    logic              w_busy_nxt, w_done_nxt, w_ram_req_nxt, w_flash_req_nxt;
    logic [23:0]       w_ram_addr_nxt, w_flash_addr_nxt;
    flash_op_t         w_flash_op_nxt;

    logic              w_start, w_buf_wr, w_buf_rd;

    // With the writer disabled the FSM never leaves IDLE, so every output stays at reset.
    assign w_start  = start & ENABLE;
    assign w_buf_wr = (r_state == S_FILL) & ram_ack;
    assign w_buf_rd = (r_state == S_PROG_WAIT) & flash_dreq;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_page  <= '0;
            r_byte  <= '0;
            r_rptr  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_page  <= w_page_nxt;
            r_byte  <= w_byte_nxt;
            r_rptr  <= w_rptr_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_byte_nxt  = r_byte;
        w_rptr_nxt  = r_rptr;
        w_error_nxt = r_error;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ERASE_REQ;
                    w_error_nxt = 1'b0;
                    w_page_nxt  = '0;
                end
            end
            S_ERASE_REQ: begin
                if (flash_ack) w_state_nxt = S_ERASE_WAIT;
            end
            S_ERASE_WAIT: begin
                if (flash_done) begin
                    if (flash_err) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_nxt  = '0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (ram_ack) begin
                    w_byte_nxt = r_byte + 1'b1;
                    if (r_byte == LAST_BYTE) w_state_nxt = S_PROG_REQ;
                end
            end
            S_PROG_REQ: begin
                if (flash_ack) begin
                    w_state_nxt = S_PROG_WAIT;
                    w_rptr_nxt  = '0;
                end
            end
            S_PROG_WAIT: begin
                // Extra pulls past one page simply wrap the pointer.
                if (flash_dreq) w_rptr_nxt = r_rptr + 1'b1;
                if (flash_done) begin
                    if (flash_err) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_page == LAST_PAGE) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_page_nxt  = r_page + 1'b1;
                        w_byte_nxt  = '0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state will drive.
    always_comb begin
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_done_nxt        = (r_state == S_FINISH);
        w_ram_req_nxt     = (w_state_nxt == S_FILL);
        w_ram_addr_nxt    = r_ram_addr;
        w_flash_req_nxt   = (w_state_nxt == S_ERASE_REQ) || (w_state_nxt == S_PROG_REQ);
        w_flash_op_nxt    = r_flash_op;
        w_flash_addr_nxt  = r_flash_addr;
        if (w_ram_req_nxt) begin
            w_ram_addr_nxt = RAM_ADDR_PAC + 24'({w_page_nxt, w_byte_nxt});
        end
        if (w_state_nxt == S_ERASE_REQ) begin
            w_flash_op_nxt   = ERASE_64K;
            w_flash_addr_nxt = FLASH_ADDR_PAC;
        end else if (w_state_nxt == S_PROG_REQ) begin
            w_flash_op_nxt   = PROGRAM_PAGE;
            w_flash_addr_nxt = FLASH_ADDR_PAC + 24'({w_page_nxt, {BYTE_W{1'b0}}});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ram_req    <= 1'b0;
            r_ram_addr   <= '0;
            r_flash_req  <= 1'b0;
            r_flash_op   <= ERASE_64K;
            r_flash_addr <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_ram_req    <= w_ram_req_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_flash_req  <= w_flash_req_nxt;
            r_flash_op   <= w_flash_op_nxt;
            r_flash_addr <= w_flash_addr_nxt;
        end
    end

    pac_page_buffer #(
        .DEPTH (PAGE_BYTES)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_buf_wr),
        .i_wr_addr (r_byte),
        .i_wr_data (ram_rdata),
        .i_rd_en   (w_buf_rd),
        .i_rd_addr (r_rptr),
        .o_rd_data (flash_wdata)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign ram_req    = r_ram_req;
    assign ram_addr   = r_ram_addr;
    assign flash_req  = r_flash_req;
    assign flash_op   = r_flash_op;
    assign flash_addr = r_flash_addr;

endmodule

// File: tb/tb_pac_flash_writer.sv
// Bench for pac_flash_writer: SD-RAM and flash responder models with random latencies,
// expected flash image and operation list derived directly from the PAC layout.
module tb_pac_flash_writer;
    import pac_flash_writer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, ram_req, flash_req, flash_op;
    logic [23:0] ram_addr, flash_addr;
    logic [7:0]  flash_wdata;
    logic        ram_ack = 1'b0;
    logic [7:0]  ram_rdata = 8'h00;
    logic        flash_ack = 1'b0, fm_dreq = 1'b0, tb_dreq = 1'b0;
    logic        flash_done = 1'b0, flash_err = 1'b0;
    logic        flash_dreq;

    assign flash_dreq = fm_dreq | tb_dreq;

    pac_flash_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .flash_req(flash_req), .flash_op(flash_op), .flash_addr(flash_addr),
        .flash_ack(flash_ack), .flash_dreq(flash_dreq), .flash_wdata(flash_wdata),
        .flash_done(flash_done), .flash_err(flash_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus configuration (written by the main sequence only)
    int         ram_lat_max = 0;
    int         flash_lat_max = 0;
    int         gap_on = 0;
    int         prog_fail_page = -1;
    bit         erase_fail = 1'b0;
    logic [7:0] ram_img [8192];

    // Responder model state (written by the model block only)
    logic [7:0]  flash_img [8192];
    int          op_q [$];
    int          cyc = 0, rm_cnt = 0, fm_st = 0, fm_lat = 0, fm_idx = 0, fm_nreq = 0;
    int          fm_gap = 0, fm_dlat = 0, fm_off = 0;
    logic        fm_pend = 1'b0, fm_op = 1'b0, rm_hold_v = 1'b0, done_prev = 1'b0;
    logic        rise_armed = 1'b0;
    logic [23:0] fm_addr = '0, rm_hold = '0;
    int          stab_err = 0, proto_err = 0, range_err = 0, timing_err = 0;
    int          done_cnt = 0, done_delay = 0, fdone_cyc = 0, erase_done_cyc = 0;
    int          ram_rise_delay = 0, ram_req_cnt = 0, ack255_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        ram_ack = 1'b0; flash_ack = 1'b0; fm_dreq = 1'b0; flash_done = 1'b0; flash_err = 1'b0;
        if (done) begin
            done_cnt++;
            done_delay = cyc - fdone_cyc;
            if (done_prev) timing_err++;
        end
        done_prev = done;
        if (!reset_n) begin
            rm_cnt = 0; rm_hold_v = 1'b0; fm_st = 0; fm_pend = 1'b0;
        end else begin
            if (ram_req) begin
                ram_req_cnt++;
                if (rise_armed) begin
                    ram_rise_delay = cyc - erase_done_cyc;
                    rise_armed = 1'b0;
                end
                if (ram_addr < RAM_ADDR_PAC || ram_addr > RAM_ADDR_PAC + RAM_SIZE_PAC - 24'd1)
                    range_err++;
                if (rm_hold_v && ram_addr !== rm_hold) stab_err++;
                if (rm_cnt == 0) begin
                    ram_ack = 1'b1;
                    ram_rdata = ram_img[13'(ram_addr - RAM_ADDR_PAC)];
                    if (ram_addr[7:0] == 8'hFF) ack255_cyc = cyc;
                    rm_cnt = (ram_lat_max > 0 && $urandom_range(0, 15) == 0) ?
                             int'($urandom_range(0, ram_lat_max)) : 0;
                    rm_hold_v = 1'b0;
                end else begin
                    rm_hold = ram_addr; rm_hold_v = 1'b1; rm_cnt--;
                end
            end else begin
                rm_hold_v = 1'b0;
            end

            if (fm_pend) begin
                if (fm_off >= 0 && fm_off + fm_idx < 8192) flash_img[fm_off + fm_idx] = flash_wdata;
                else range_err++;
                fm_idx++; fm_pend = 1'b0;
            end
            case (fm_st)
                0: if (flash_req) begin
                    fm_op = flash_op; fm_addr = flash_addr;
                    fm_off = int'(fm_addr) - int'(FLASH_ADDR_PAC);
                    op_q.push_back(int'({7'd0, fm_op, fm_addr}));
                    if (fm_op && (cyc - ack255_cyc) != 1) timing_err++;
                    fm_lat = int'($urandom_range(0, flash_lat_max));
                    fm_st = 1;
                end
                1: begin
                    if (!flash_req || flash_op !== fm_op || flash_addr !== fm_addr) stab_err++;
                    if (fm_lat == 0) begin
                        flash_ack = 1'b1;
                        fm_idx = 0; fm_nreq = 0; fm_gap = 0;
                        fm_dlat = int'($urandom_range(0, flash_lat_max));
                        fm_st = fm_op ? 2 : 3;
                    end else fm_lat--;
                end
                2: begin
                    if (flash_req) proto_err++;
                    if (fm_nreq < 256) begin
                        if (fm_gap == 0) begin
                            fm_dreq = 1'b1; fm_pend = 1'b1; fm_nreq++;
                            fm_gap = (gap_on != 0 && $urandom_range(0, 7) == 0) ?
                                     int'($urandom_range(1, 3)) : 0;
                        end else fm_gap--;
                    end else if (!fm_pend) fm_st = 3;
                end
                3: begin
                    if (flash_req) proto_err++;
                    if (fm_dlat == 0) begin
                        flash_done = 1'b1;
                        fdone_cyc = cyc;
                        flash_err = fm_op ? (prog_fail_page == fm_off / 256) : erase_fail;
                        if (!fm_op && !erase_fail) begin
                            for (int i = 0; i < 8192; i++) flash_img[i] = 8'hFF;
                            rise_armed = 1'b1;
                            erase_done_cyc = cyc;
                        end
                        fm_st = 0;
                    end else fm_dlat--;
                end
                default: fm_st = 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_op(input int k);
        return (k == 0) ? 32'h001F_0000 : 32'h011F_0000 + (k - 1) * 256;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_ram_req"}, ram_req, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_flash_req"}, flash_req, 0);
        chk({tag, "_flash_op"}, flash_op, 0);
        chk({tag, "_flash_addr"}, flash_addr, 0);
        chk({tag, "_flash_wdata"}, flash_wdata, 0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_erase_req"}, {flash_req, flash_op, flash_addr}, {2'b10, FLASH_ADDR_PAC});
    endtask

    task automatic wait_end(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_end_seen"}, seen, 1);
        chk({tag, "_busy_fall"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
    endtask

    task automatic check_full(input string tag, input int op_base, input int done_base);
        int bad = 0;
        chk({tag, "_op_count"}, op_q.size() - op_base, 33);
        for (int k = 0; k < 33 && op_base + k < op_q.size(); k++)
            if (op_q[op_base + k] != exp_op(k)) bad++;
        chk({tag, "_op_seq"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 8192; i++) if (flash_img[i] !== ram_img[i]) bad++;
        chk({tag, "_image"}, bad, 0);
        chk({tag, "_done_cnt"}, done_cnt - done_base, 1);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        int op_base, done_base, rq_base, erase_cnt;
        logic [7:0] last_w;
        bit reached;
        for (int i = 0; i < 8192; i++) begin
            logic [12:0] a;
            a = 13'(i);
            ram_img[i] = a[7:0] ^ {3'b000, a[12:8]};
        end

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Full save with zero-wait responders
        op_base = op_q.size(); done_base = done_cnt;
        do_start("t1");
        wait_end("t1");
        check_full("t1", op_base, done_base);
        chk("t1_ram_rise_delay", ram_rise_delay, 1);
        chk("t1_done_delay", done_delay, 2);

        // flash_dreq while idle must not disturb flash_wdata
        last_w = ram_img[8191];
        chk("idle_wdata_last", flash_wdata, last_w);
        tb_dreq = 1'b1;
        @(negedge clk);
        tb_dreq = 1'b0;
        @(negedge clk);
        chk("idle_dreq_hold", flash_wdata, last_w);

        // Erase failure
        erase_fail = 1'b1;
        op_base = op_q.size(); done_base = done_cnt; rq_base = ram_req_cnt;
        do_start("t2");
        wait_end("t2");
        chk("t2_error", error, 1);
        chk("t2_no_ram_req", ram_req_cnt - rq_base, 0);
        chk("t2_no_done", done_cnt - done_base, 0);
        chk("t2_op_count", op_q.size() - op_base, 1);
        erase_fail = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_error_sticky", error, 1);

        // Program failure on page 5, random image
        for (int i = 0; i < 8192; i++) ram_img[i] = 8'($urandom);
        prog_fail_page = 5;
        op_base = op_q.size(); done_base = done_cnt;
        do_start("t3");
        wait_end("t3");
        chk("t3_error", error, 1);
        chk("t3_op_count", op_q.size() - op_base, 7);
        chk("t3_last_op", op_q[op_q.size() - 1], 32'h011F_0500);
        rq_base = ram_req_cnt;
        repeat (20) @(negedge clk);
        chk("t3_no_page6", op_q.size() - op_base, 7);
        chk("t3_no_ram_after", ram_req_cnt - rq_base, 0);
        chk("t3_no_done", done_cnt - done_base, 0);

        // Restart clears error; random handshake latencies
        prog_fail_page = -1;
        ram_lat_max = 20; flash_lat_max = 3; gap_on = 1;
        op_base = op_q.size(); done_base = done_cnt;
        do_start("t4");
        chk("t4_error_cleared", error, 0);
        wait_end("t4");
        check_full("t4", op_base, done_base);
        ram_lat_max = 0; flash_lat_max = 0; gap_on = 0;

        // Ignored start during FILL, then reset inside PROG_WAIT
        op_base = op_q.size();
        do_start("t5");
        repeat (40) @(negedge clk);
        chk("t5_in_fill", ram_req, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_start_ignored_busy", busy, 1);
        reached = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (op_q.size() - op_base >= 4 && fm_st == 2) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t5_reached_prog_wait", reached, 1);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("t5_midreset");
        reset_n = 1'b1;
        erase_cnt = 0;
        for (int k = op_base; k < op_q.size(); k++) if (op_q[k][24] == 1'b0) erase_cnt++;
        chk("t5_single_erase", erase_cnt, 1);
        chk("t5_op_count", op_q.size() - op_base, 4);
        repeat (3) @(negedge clk);
        chk_reset_vals("t5_idle_after_reset");

        for (int i = 0; i < 8192; i++) ram_img[i] = 8'($urandom);
        op_base = op_q.size(); done_base = done_cnt;
        do_start("t6");
        wait_end("t6");
        check_full("t6", op_base, done_base);

        chk("stability", stab_err, 0);
        chk("protocol", proto_err, 0);
        chk("addr_range", range_err, 0);
        chk("timing", timing_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
